// File: rtl/deint_pkg.sv
// Shared constants and state encoding for the 4x11 block deinterleaver.
package deint_pkg;

  localparam int ROWS    = 4;
  localparam int COLS    = 11;
  localparam int FRAME_W = ROWS * COLS;
  localparam int CNT_W   = 6;

  typedef enum logic {
    FILL,
    FULL
  } state_e;

endpackage

// File: rtl/deinterleaver_if.sv
// Serial input / parallel output handshake bundle of the deinterleaver.
interface deinterleaver_if;
  import deint_pkg::*;

  logic               in_bit;
  logic               in_sof;
  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] data_out;
  logic               out_valid;
  logic               out_ready;
  logic               frame_err;

  modport master (
    output in_bit, in_sof, in_valid, out_ready,
    input  in_ready, data_out, out_valid, frame_err
  );

  modport slave (
    input  in_bit, in_sof, in_valid, out_ready,
    output in_ready, data_out, out_valid, frame_err
  );

endinterface

// File: rtl/deint_perm.sv
// Combinational inverse permutation: x[43-r-11c] = y[43-4r-c].
module deint_perm
  import deint_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 11
) (
  input  logic [FRAME_W-1:0] y_i,
  output logic [FRAME_W-1:0] x_o
);

  always_comb begin
    x_o = '0;
    for (int unsigned r = 0; r < COLS; r++) begin
      for (int unsigned c = 0; c < ROWS; c++) begin
        x_o[FRAME_W-1-r-COLS*c] = y_i[FRAME_W-1-ROWS*r-c];
      end
    end
  end

endmodule

// File: rtl/deinterleaver.sv
// Serial-to-parallel 4x11 deinterleaver with SOF framing and output backpressure.
module deinterleaver
  import deint_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  deinterleaver_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] cap_q, cap_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               ov_q, ov_d;
  logic               ferr_q, ferr_d;

  logic               accept;
  logic               load;
  logic [FRAME_W-1:0] frame_w;
  logic [FRAME_W-1:0] y_w;
  logic [FRAME_W-1:0] perm_w;

  assign bus.in_ready  = (state_q == FILL);
  assign bus.data_out  = data_q;
  assign bus.out_valid = ov_q;
  assign bus.frame_err = ferr_q;

  assign accept = bus.in_valid & bus.in_ready;

  // While filling, the last bit is still on the wire, so splice it in directly.
  always_comb begin
    frame_w = cap_q;
    if (state_q == FILL) frame_w[FRAME_W-1] = bus.in_bit;
    y_w = '0;
    for (int unsigned k = 0; k < FRAME_W; k++) begin
      y_w[FRAME_W-1-k] = frame_w[k];
    end
  end

  deint_perm #(.ROWS(ROWS), .COLS(COLS)) u_perm (
    .y_i (y_w),
    .x_o (perm_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    data_d  = data_q;
    ov_d    = ov_q;
    ferr_d  = 1'b0;
    load    = 1'b0;

    if (ov_q && bus.out_ready) ov_d = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (bus.in_sof && (cnt_q != '0)) begin
            cap_d    = '0;
            cap_d[0] = bus.in_bit;
            cnt_d    = CNT_W'(1);
            ferr_d   = 1'b1;
          end else if (!bus.in_sof && (cnt_q == '0)) begin
            ferr_d = 1'b1;
          end else if (cnt_q == LAST) begin
            cnt_d = '0;
            if (!ov_q || bus.out_ready) begin
              load = 1'b1;
            end else begin
              cap_d[LAST] = bus.in_bit;
              state_d     = FULL;
            end
          end else begin
            cap_d[cnt_q] = bus.in_bit;
            cnt_d        = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          load    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (load) begin
      data_d = perm_w;
      ov_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      ov_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      ov_q    <= ov_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule
